m68k_bus_bridge: RTL and testbench
==================================

Name: m68k_bus_bridge

Overview:
Upstream stage of the on-chip word memory. Converts the 68000 asynchronous bus (AS/UDS/LDS/RW/DTACK) into the memory's single-cycle synchronous strobe interface (addr, ds, rw, data_write/data_read, ack). Synchronises CPU strobes, issues exactly one memory cycle per bus cycle, latches read data and holds DTACK until the CPU releases AS.

Parameters:
MEM_WORDS, 8192, number of 16-bit words decoded as memory; word index >= MEM_WORDS is out of range.
SYNC_STAGES, 2, flip-flop depth of the AS/UDS/LDS synchronisers (min 2).
TIMEOUT_CYCLES, 64, clk cycles from access start to bus error (used only with BUS_TIMEOUT_EN).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_as_n  in  1  68000 address strobe, active low, asynchronous.
cpu_uds_n  in  1  upper data strobe, active low.
cpu_lds_n  in  1  lower data strobe, active low.
cpu_rw  in  1  1 = read, 0 = write.
cpu_addr  in  23  CPU A23..A1 (word address).
cpu_data_out  in  16  CPU write data.
cpu_data_in  out  16  read data to CPU.
cpu_dtack_n  out  1  data acknowledge, active low.
cpu_berr_n  out  1  bus error, active low.
mem_addr  out  24  word index to memory ({1'b0, cpu_addr}).
mem_ds  out  2  memory byte strobes, active low; [1] = upper, [0] = lower.
mem_rw  out  1  memory direction.
mem_data_write  out  16  memory write data.
mem_data_read  in  16  memory read data (combinational from mem_addr).
mem_ack  in  1  memory acknowledge, registered.

Behaviour:
- Reset (async, active-high) values: cpu_dtack_n=1, cpu_berr_n=1, cpu_data_in=0, mem_ds=2'b11, mem_rw=1, mem_addr=0, mem_data_write=0, state=IDLE, synchronisers all 1.
- Idle memory bus: mem_ds=11, mem_rw=1. Memory acks every cycle while rw=1, so mem_ack is ignored outside WAIT_ACK.
- cpu_addr, cpu_rw and cpu_data_out are sampled only once synchronised AS is low; 68000 timing guarantees they are stable by then.
- FSM states and transitions:
  IDLE: wait for synced AS=0 and (synced UDS=0 or LDS=0). Then latch addr, rw, data and strobes.
    In range: go to ACCESS. Out of range: go to DECERR.
  ACCESS: exactly one cycle. Drive mem_ds={uds_n,lds_n}, mem_rw, mem_addr, mem_data_write. Go to WAIT_ACK.
    A write strobe is never held longer than one cycle.
  WAIT_ACK: mem_ds=11, mem_rw=1, mem_addr held. When mem_ack=1, latch mem_data_read into cpu_data_in on reads, then go to DTACK.
    The memory's registered ack arrives on the clk edge ending ACCESS, so the nominal path is ACCESS -> WAIT_ACK -> DTACK.
  DTACK: cpu_dtack_n=0. Stay until synced AS=1, then cpu_dtack_n=1 and go to IDLE.
  DECERR: without the macro, reads return 16'hFFFF, writes are dropped, then go to DTACK. With the macro, see Optional Feature.
- Latency: read-modify-write (TAS) is handled as two ordinary cycles because AS stays low. A second access needs DS to deassert: after DTACK, require synced UDS=LDS=1 before re-arming.
- Byte access: only the strobed lane is written. On reads both lanes are returned and the CPU selects.
- Reset mid-cycle returns the FSM to IDLE and releases DTACK immediately. A CPU left waiting re-requests naturally on the next AS.
- AS rising in ACCESS/WAIT_ACK (aborted cycle): the memory cycle completes, DTACK is not asserted, return to IDLE.

Optional Feature:
Macro BUS_TIMEOUT_EN.
- Defined: a counter starts at ACCESS/DECERR entry. If it reaches TIMEOUT_CYCLES without mem_ack, or the access is out of range, assert cpu_berr_n=0 (DTACK stays 1) until synced AS=1, then go to IDLE.
- Undefined: no counter, cpu_berr_n tied to 1, out-of-range handling as in Behaviour.

Decomposition:
- Shared package m68k_bus_pkg: FSM state enum, DS_IDLE=2'b11 constant, open-bus read value 16'hFFFF, default MEM_WORDS.
- One sub-module: m68k_sync (parameterised SYNC_STAGES flip-flop chain, reset to 1), instanced for AS, UDS and LDS.

Test Plan:
- Word write 16'hBEEF to cpu_addr 0x000010 -> mem_ds=00 and mem_rw=0 for exactly 1 cycle at mem_addr 0x10; DTACK low until AS high; readback returns 16'hBEEF.
- Byte write with only LDS low, data 16'h1234, onto word 16'hBEEF -> mem_ds=10; subsequent read returns 16'hBE34.
- Read at word index 8192 (out of range), macro off -> cpu_data_in=16'hFFFF, DTACK asserted, mem_ds stays 11.
- Macro on, mem_ack forced 0 -> cpu_berr_n=0 after exactly 64 cycles, DTACK never asserted; BERR released one sync delay after AS high.
- Reset pulsed during WAIT_ACK -> cpu_dtack_n=1 and mem_ds=11 immediately (async); next CPU cycle completes normally.
- Back-to-back reads with AS held and DS toggled -> two memory cycles, two DTACKs, no duplicated write strobes.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-to-word-memory bus bridge.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT_ACK,
        ST_DTACK,
        ST_DECERR,
        ST_BERR
    } bridge_state_t;

    localparam logic [1:0]  DS_IDLE          = 2'b11;
    localparam logic [15:0] OPEN_BUS_DATA    = 16'hFFFF;
    localparam int          MEM_WORDS_DEFAULT = 8192;

endpackage

// File: rtl/m68k_sync.sv
// Flip-flop synchroniser for an active-low asynchronous CPU strobe; resets to the inactive level.
module m68k_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_bridge.sv
// 68000 asynchronous bus to single-cycle synchronous word-memory bridge.
// Optional bus-error timeout enabled by defining BUS_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for AS and a data strobe, re-armed once both DS seen high
// ACCESS   | one-cycle memory strobe
// WAIT_ACK | strobes idle, waiting for the memory ack, read data captured
// DTACK    | DTACK low until AS (or both DS) released
// DECERR   | address outside the decoded memory
// BERR     | bus error held until AS released (BUS_TIMEOUT_EN only)
module m68k_bus_bridge
    import m68k_bus_pkg::*;
#(
    parameter int MEM_WORDS      = MEM_WORDS_DEFAULT,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw,
    input  logic [22:0] cpu_addr,
    input  logic [15:0] cpu_data_out,
    output logic [15:0] cpu_data_in,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    output logic [23:0] mem_addr,
    output logic [1:0]  mem_ds,
    output logic        mem_rw,
    output logic [15:0] mem_data_write,
    input  logic [15:0] mem_data_read,
    input  logic        mem_ack
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("m68k_bus_bridge: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("m68k_bus_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    logic as_s, uds_s, lds_s;

    m68k_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_as  (.clk(clk), .reset(reset), .d(cpu_as_n),  .q(as_s));
    m68k_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uds (.clk(clk), .reset(reset), .d(cpu_uds_n), .q(uds_s));
    m68k_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lds (.clk(clk), .reset(reset), .d(cpu_lds_n), .q(lds_s));

    bridge_state_t state_q, state_d;
    logic [23:0] addr_q;
    logic [15:0] wdata_q, rdata_q;
    logic [1:0]  ds_q;
    logic        rw_q;
    logic        armed_q;
    logic        start;
    logic        in_range;

    // A new access needs both data strobes seen high since the previous one (TAS keeps AS low).
    assign start    = (state_q == ST_IDLE) && !as_s && (!uds_s || !lds_s) && armed_q;
    assign in_range = {1'b0, cpu_addr} < 24'(MEM_WORDS);

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (start) begin
            tmo_q <= TW'(TIMEOUT_CYCLES - 1);
        end else if (tmo_q != '0 && (state_q == ST_ACCESS || state_q == ST_WAIT_ACK)) begin
            tmo_q <= tmo_q - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = in_range ? ST_ACCESS : ST_DECERR;
            ST_ACCESS:   state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (mem_ack) begin
                    state_d = as_s ? ST_IDLE : ST_DTACK;
                end
`ifdef BUS_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    state_d = ST_BERR;
                end
`endif
            end
            ST_DTACK:    if (as_s || (uds_s && lds_s)) state_d = ST_IDLE;
`ifdef BUS_TIMEOUT_EN
            ST_DECERR:   state_d = ST_BERR;
`else
            ST_DECERR:   state_d = ST_DTACK;
`endif
            ST_BERR:     if (as_s) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ds_q    <= DS_IDLE;
            rw_q    <= 1'b1;
            armed_q <= 1'b1;
        end else begin
            if (start) begin
                addr_q  <= {1'b0, cpu_addr};
                wdata_q <= cpu_data_out;
                ds_q    <= {uds_s, lds_s};
                rw_q    <= cpu_rw;
                armed_q <= 1'b0;
            end else if (uds_s && lds_s) begin
                armed_q <= 1'b1;
            end
            if (state_q == ST_WAIT_ACK && mem_ack && rw_q) begin
                rdata_q <= mem_data_read;
            end else if (state_q == ST_DECERR && rw_q) begin
                rdata_q <= OPEN_BUS_DATA;
            end
        end
    end

    always_comb begin
        mem_ds      = DS_IDLE;
        mem_rw      = 1'b1;
        cpu_dtack_n = 1'b1;
        if (state_q == ST_ACCESS) begin
            mem_ds = ds_q;
            mem_rw = rw_q;
        end
        if (state_q == ST_DTACK) begin
            cpu_dtack_n = 1'b0;
        end
    end

`ifdef BUS_TIMEOUT_EN
    assign cpu_berr_n = (state_q != ST_BERR);
`else
    assign cpu_berr_n = 1'b1;
`endif

    assign mem_addr       = addr_q;
    assign mem_data_write = wdata_q;
    assign cpu_data_in    = rdata_q;

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// Self-checking bench for m68k_bus_bridge: vector table, strobe/read-data scoreboards, reset and TAS sequences.
module tb_m68k_bus_bridge;
    import m68k_bus_pkg::*;

`ifdef BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
    logic [22:0] cpu_addr;
    logic [15:0] cpu_data_out;
    logic [15:0] cpu_data_in;
    logic        cpu_dtack_n, cpu_berr_n;
    logic [23:0] mem_addr;
    logic [1:0]  mem_ds;
    logic        mem_rw;
    logic [15:0] mem_data_write;
    logic [15:0] mem_data_read;
    logic        mem_ack;
    logic        force_nack;

    always #5 clk = ~clk;

    m68k_bus_bridge #(.MEM_WORDS(8192), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
        .cpu_data_in(cpu_data_in), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
        .mem_addr(mem_addr), .mem_ds(mem_ds), .mem_rw(mem_rw),
        .mem_data_write(mem_data_write), .mem_data_read(mem_data_read), .mem_ack(mem_ack)
    );

    // Memory stub: byte-lane writes, combinational read, registered ack.
    logic [15:0] mem [0:8191];
    assign mem_data_read = mem[mem_addr[12:0]];
    always @(posedge clk) begin
        if (mem_ds != 2'b11 && !mem_rw) begin
            if (!mem_ds[1]) mem[mem_addr[12:0]][15:8] <= mem_data_write[15:8];
            if (!mem_ds[0]) mem[mem_addr[12:0]][7:0]  <= mem_data_write[7:0];
        end
        mem_ack <= !force_nack && ((mem_ds != 2'b11) || mem_rw);
    end

    typedef struct {
        bit          rw;
        bit          uds_n;
        bit          lds_n;
        logic [22:0] addr;
        logic [15:0] wd;
        logic [1:0]  exp_ds;
        logic [15:0] exp_rd;
        bit          oor;
    } vec_t;

    typedef struct {
        logic [23:0] addr;
        logic [1:0]  ds;
        logic        rw;
        logic [15:0] wd;
    } strobe_t;

    vec_t        vecs [12];
    strobe_t     strobe_q [$];
    logic [15:0] rd_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_strobe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_strobe(input logic [22:0] addr, input logic [1:0] ds, input logic rw, input logic [15:0] wd);
        strobe_t s;
        s.addr = {1'b0, addr};
        s.ds   = ds;
        s.rw   = rw;
        s.wd   = wd;
        strobe_q.push_back(s);
    endtask

    task automatic wait_signal(input string name, input bit want_dtack_low, output bit got);
        int k = 0;
        got = 1'b0;
        while (k < 100 && !got) begin
            @(negedge clk);
            k++;
            if (want_dtack_low) got = !cpu_dtack_n || !cpu_berr_n;
            else                got = cpu_dtack_n && cpu_berr_n;
        end
        check(name, {31'd0, got}, 32'd1);
    endtask

    task automatic cpu_cycle(input vec_t v, input string tag);
        int  s0 = n_strobe;
        int  held;
        bit  got;
        bit  exp_berr = TMO_EN && v.oor;
        logic [15:0] e;
        @(negedge clk);
        cpu_addr = v.addr;
        cpu_rw = v.rw;
        cpu_data_out = v.wd;
        if (!v.oor) push_strobe(v.addr, v.exp_ds, v.rw, v.wd);
        if (v.rw && !exp_berr) rd_q.push_back(v.exp_rd);
        cpu_as_n = 1'b0;
        cpu_uds_n = v.uds_n;
        cpu_lds_n = v.lds_n;
        wait_signal({tag, "_ack_seen"}, 1'b1, got);
        if (got) begin
            check({tag, "_dtack_berr"}, {30'd0, cpu_dtack_n, cpu_berr_n}, exp_berr ? 32'd2 : 32'd1);
            if (v.rw && !exp_berr) begin
                e = rd_q.pop_front();
                check({tag, "_rdata"}, {16'd0, cpu_data_in}, {16'd0, e});
            end
            held = 0;
            repeat (3) begin
                @(negedge clk);
                if (!cpu_dtack_n || !cpu_berr_n) held++;
            end
            check({tag, "_ack_held"}, held, 3);
        end
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        wait_signal({tag, "_ack_release"}, 1'b0, got);
        check({tag, "_strobe_count"}, n_strobe - s0, v.oor ? 0 : 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit got;
        bit found;
        int s0;
        int cnt;
        bit dt_seen;
        logic [15:0] e;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 23'h000010, 16'hBEEF, 2'b00, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 23'h000010, 16'h0000, 2'b00, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 23'h000010, 16'h1234, 2'b10, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 23'h000010, 16'h0000, 2'b00, 16'hBE34, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 23'h001FFF, 16'h5A5A, 2'b00, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 23'h001FFF, 16'hC3C3, 2'b01, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 23'h001FFF, 16'h0000, 2'b00, 16'hC35A, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 23'h002000, 16'h0000, 2'b00, 16'hFFFF, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 23'h002010, 16'hDEAD, 2'b00, 16'h0000, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 23'h000010, 16'h0000, 2'b00, 16'hBE34, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 23'h7FFFFF, 16'h0000, 2'b00, 16'hFFFF, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 23'h000010, 16'h0000, 2'b01, 16'hBE34, 1'b0};

        reset = 1'b1;
        force_nack = 1'b0;
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cpu_rw = 1'b1;
        cpu_addr = '0;
        cpu_data_out = '0;

        fork
            forever begin
                strobe_t s;
                @(negedge clk);
                if (mem_ds !== DS_IDLE) begin
                    n_strobe++;
                    if (strobe_q.size() == 0) begin
                        check("unexpected_strobe", {6'd0, mem_addr, mem_ds}, 32'hFFFF_FFFF);
                    end else begin
                        s = strobe_q.pop_front();
                        check("strobe_addr_ds_rw", {5'd0, mem_addr, mem_ds, mem_rw}, {5'd0, s.addr, s.ds, s.rw});
                        if (!s.rw) check("strobe_wdata", {16'd0, mem_data_write}, {16'd0, s.wd});
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_dtack_berr", {30'd0, cpu_dtack_n, cpu_berr_n}, 32'd3);
        check("rst_data_in", {16'd0, cpu_data_in}, 32'd0);
        check("rst_mem_ds_rw", {29'd0, mem_ds, mem_rw}, 32'd7);
        check("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_data_write}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            cpu_cycle(vecs[i], $sformatf("vec%0d", i));
        end

        // TAS-style: AS held low, data strobes toggled between two reads.
        s0 = n_strobe;
        @(negedge clk);
        cpu_addr = 23'h000010;
        cpu_rw = 1'b1;
        push_strobe(23'h000010, 2'b00, 1'b1, 16'h0);
        rd_q.push_back(16'hBE34);
        cpu_as_n = 1'b0;
        cpu_uds_n = 1'b0;
        cpu_lds_n = 1'b0;
        wait_signal("b2b_ack1", 1'b1, got);
        e = rd_q.pop_front();
        check("b2b_rdata1", {16'd0, cpu_data_in}, {16'd0, e});
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        wait_signal("b2b_release1", 1'b0, got);
        cpu_addr = 23'h001FFF;
        push_strobe(23'h001FFF, 2'b00, 1'b1, 16'h0);
        rd_q.push_back(16'hC35A);
        cpu_uds_n = 1'b0;
        cpu_lds_n = 1'b0;
        wait_signal("b2b_ack2", 1'b1, got);
        e = rd_q.pop_front();
        check("b2b_rdata2", {16'd0, cpu_data_in}, {16'd0, e});
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        wait_signal("b2b_release2", 1'b0, got);
        check("b2b_strobe_count", n_strobe - s0, 2);

        // Asynchronous reset while DTACK is asserted.
        @(negedge clk);
        cpu_addr = 23'h000010;
        cpu_rw = 1'b1;
        push_strobe(23'h000010, 2'b00, 1'b1, 16'h0);
        rd_q.push_back(16'hBE34);
        cpu_as_n = 1'b0;
        cpu_uds_n = 1'b0;
        cpu_lds_n = 1'b0;
        wait_signal("rstdt_ack", 1'b1, got);
        e = rd_q.pop_front();
        check("rstdt_rdata", {16'd0, cpu_data_in}, {16'd0, e});
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstdt_dtack", {31'd0, cpu_dtack_n}, 32'd1);
        check("rstdt_data_in", {16'd0, cpu_data_in}, 32'd0);
        check("rstdt_mem_addr", {8'd0, mem_addr}, 32'd0);
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset while waiting for the memory ack.
        force_nack = 1'b1;
        cpu_addr = 23'h000010;
        cpu_rw = 1'b1;
        push_strobe(23'h000010, 2'b00, 1'b1, 16'h0);
        cpu_as_n = 1'b0;
        cpu_uds_n = 1'b0;
        cpu_lds_n = 1'b0;
        found = 1'b0;
        cnt = 0;
        while (cnt < 20 && !found) begin
            @(negedge clk);
            cnt++;
            found = (mem_ds !== DS_IDLE);
        end
        check("rstwa_access_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstwa_dtack", {31'd0, cpu_dtack_n}, 32'd1);
        check("rstwa_mem_ds_rw", {29'd0, mem_ds, mem_rw}, 32'd7);
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        force_nack = 1'b0;
        repeat (2) @(negedge clk);
        cpu_cycle(vecs[9], "post_reset_read");

`ifdef BUS_TIMEOUT_EN
        force_nack = 1'b1;
        @(negedge clk);
        cpu_addr = 23'h000010;
        cpu_rw = 1'b1;
        push_strobe(23'h000010, 2'b00, 1'b1, 16'h0);
        cpu_as_n = 1'b0;
        cpu_uds_n = 1'b0;
        cpu_lds_n = 1'b0;
        found = 1'b0;
        cnt = 0;
        while (cnt < 20 && !found) begin
            @(negedge clk);
            cnt++;
            found = (mem_ds !== DS_IDLE);
        end
        check("tmo_access_seen", {31'd0, found}, 32'd1);
        cnt = 0;
        dt_seen = 1'b0;
        while (cnt < 200 && cpu_berr_n) begin
            @(negedge clk);
            cnt++;
            if (!cpu_dtack_n) dt_seen = 1'b1;
        end
        check("tmo_berr_cycles", cnt, 64);
        check("tmo_no_dtack", {31'd0, dt_seen}, 32'd0);
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cnt = 0;
        while (cnt < 20 && !cpu_berr_n) begin
            @(negedge clk);
            cnt++;
        end
        check("tmo_berr_release", cnt, SYNC + 1);
        force_nack = 1'b0;
        repeat (3) @(negedge clk);
`endif

        check("strobe_queue_empty", strobe_q.size(), 0);
        check("rdata_queue_empty", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
